axi_sram_slave: RTL and testbench
=================================

# axi_sram_slave

- AXI3-style slave responder backed by an on-chip word array.
- Terminates the CPU core's AXI master port: answers AR/R and AW/W/B with the widths the core drives.
- Used as the SoC-level memory model for simulation and FPGA bring-up of the pipelined core.
- Independent read and write engines; single-ID, in-order, one outstanding transaction per direction.

## Interface
Parameters:
- ADDR_W, 16, word-index bits; array holds 2^ADDR_W 32-bit words (256 KB at default)

Ports:
- aclk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address
- arlock/arcache/arprot  in  2/4/3  ignored
- arvalid  in  1; arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1; rready  in  1
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2  write address
- awlock/awcache/awprot  in  2/4/3  ignored
- awvalid  in  1; awready  out  1
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  (wid, wlast ignored); wready  out  1
- bid/bresp/bvalid  out  4/2/1; bready  in  1

## Operation
- Word index of a beat = addr[ADDR_W+1:2]; sub-word alignment comes from wstrb only.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On arvalid&&arready, latch id, addr, len, size, burst; beat counter cleared; go R_DATA.
  - R_DATA: rvalid=1, rdata=array[word index of current beat], rid=latched id, rlast=(count==len).
  - On rvalid&&rready: non-last beat -> addr += 1<<size for INCR and WRAP (WRAP handled as INCR), addr unchanged for FIXED, count += 1. Last beat -> R_IDLE.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1, wready=0; W beats never accepted before AW.
  - W_DATA: wready=1. Each wvalid&&wready writes byte lanes with wstrb[i]=1; lanes with 0 stay unchanged. Address advances by the read-side rules.
  - Beat count==awlen ends the burst -> W_RESP. wlast is not checked.
  - W_RESP: bvalid=1, bid=latched awid; holds until bready -> W_IDLE.
- Same word read and written in one cycle: rdata shows the pre-write contents. The write is visible from the next cycle.
- rresp/bresp = 2'b00 (OKAY) unless changed by Configuration.
- arsize/awsize > 2: treated as 2.

## Timing
- Reset (async assert, sync release): R_IDLE/W_IDLE, counters cleared.
  - All outputs are 0 while aresetn=0, including arready and awready. rdata=0, rid/bid=0, rresp/bresp=0.
  - arready and awready rise in the first cycle after release.
  - Array contents are not reset.
- Read latency: AR handshake in cycle N -> first rvalid in N+1. Back-to-back beats issue every cycle while rready=1.
- After the last R handshake in cycle M, arready=1 in M+1. Single-beat read throughput is one transaction per 2 cycles.
- Write: AW in N -> wready from N+1. Last W in M -> bvalid in M+1. B handshake in K -> awready in K+1.
- Output stability: while rvalid=1 and rready=0, rdata/rid/rresp/rlast hold. bvalid/bid/bresp hold until bready.
- Read and write engines operate fully concurrently. A simultaneous arvalid and awvalid are both accepted in the same cycle.
- Reset asserted mid-burst: the transaction is abandoned immediately and no response is issued. Partially written beats remain in the array.

## Configuration
- AXI_SLV_RANGE_CHECK_EN defined:
  - A beat with addr[31:ADDR_W+2] != 0 is out of range.
  - Read beats: rdata=0, rresp=2'b10 (SLVERR).
  - Write beats: dropped, and bresp=2'b10 if any beat of the burst was out of range.
  - In-range beats behave normally.
- Not defined: upper address bits are ignored (addresses alias modulo 2^(ADDR_W+2)) and responses are always OKAY.

## Test plan
- Single write then read: AW 0x100 len 0, W 0xDEADBEEF strb 0xF, bready=1 -> bvalid one cycle after W, bresp=0. AR 0x100 -> rdata 0xDEADBEEF, rlast=1, rvalid one cycle after AR.
- Byte strobes: word 0x200 holds 0x11223344; write 0xAABBCCDD strb 4'b0101 -> readback 0x11BB33DD.
- INCR burst: AW 0x300 len 3 size 2, data 1..4 -> AR 0x300 len 3 returns 1,2,3,4; rlast only on the 4th beat. FIXED burst len 3 at 0x400 with data 5..8 -> word 0x400 reads 8.
- Backpressure: read len 1 with rready low for 3 cycles -> rvalid stays 1 and rdata is stable; bready low for 5 cycles -> bvalid, bid held, awready 0.
- Concurrency and reset: simultaneous AR and AW accepted in the same cycle; aresetn pulsed mid read burst -> all outputs 0 at once, arready=1 in the first cycle after release.
- Range check (macro on, ADDR_W=16): AR 0x0004_0000 -> rresp 2'b10, rdata 0. Write there -> bresp 2'b10 and word 0 unchanged. Macro off -> the same read returns word 0 with OKAY.

Source files
------------

// File: rtl/axi_sram_slave.sv
// rtl/axi_sram_slave.sv - AXI3 slave responder backed by a 2^ADDR_W x 32-bit word array.
// Optional AXI_SLV_RANGE_CHECK_EN: beats above the array answer SLVERR instead of aliasing.
module axi_sram_slave #(
    parameter int ADDR_W = 16
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic [1:0]  arlock,
    input  logic [3:0]  arcache,
    input  logic [2:0]  arprot,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic [1:0]  awlock,
    input  logic [3:0]  awcache,
    input  logic [2:0]  awprot,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    r_state_t    r_state, r_state_nxt;
    logic [3:0]  r_id;
    logic [31:0] r_addr;
    logic [7:0]  r_len, r_cnt;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic        r_oor;

    w_state_t    w_state, w_state_nxt;
    logic [3:0]  w_id;
    logic [31:0] w_addr;
    logic [7:0]  w_len, w_cnt;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic        w_oor, w_err;

    logic [ADDR_W-1:0] r_idx, w_idx;
    assign r_idx = r_addr[ADDR_W+1:2];
    assign w_idx = w_addr[ADDR_W+1:2];

`ifdef AXI_SLV_RANGE_CHECK_EN
    assign r_oor = |r_addr[31:ADDR_W+2];
    assign w_oor = |w_addr[31:ADDR_W+2];
`else
    assign r_oor = 1'b0;
    assign w_oor = 1'b0;
`endif

    // FIXED keeps the address; INCR and WRAP both step by the (clamped) beat size
    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [2:0] size,
                                              input logic [1:0] burst);
        logic [2:0] s;
        s = (size > 3'd2) ? 3'd2 : size;
        next_addr = (burst == 2'b00) ? a : a + (32'd1 << s);
    endfunction

    always_comb begin
        r_state_nxt = r_state;
        arready     = 1'b0;
        rvalid      = 1'b0;
        rlast       = 1'b0;
        rdata       = '0;
        rresp       = 2'b00;
        rid         = r_id;
        case (r_state)
            R_IDLE: begin
                arready = aresetn;
                if (arvalid) r_state_nxt = R_DATA;
            end
            R_DATA: begin
                rvalid = 1'b1;
                rlast  = (r_cnt == r_len);
                rdata  = r_oor ? 32'd0 : mem[r_idx];
                rresp  = r_oor ? 2'b10 : 2'b00;
                if (rready && r_cnt == r_len) r_state_nxt = R_IDLE;
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= R_IDLE;
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
        end else begin
            r_state <= r_state_nxt;
            if (r_state == R_IDLE && arvalid) begin
                r_id    <= arid;
                r_addr  <= araddr;
                r_len   <= arlen;
                r_size  <= arsize;
                r_burst <= arburst;
                r_cnt   <= '0;
            end else if (r_state == R_DATA && rready && r_cnt != r_len) begin
                r_addr <= next_addr(r_addr, r_size, r_burst);
                r_cnt  <= r_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = w_state;
        awready     = 1'b0;
        wready      = 1'b0;
        bvalid      = 1'b0;
        bresp       = 2'b00;
        bid         = w_id;
        case (w_state)
            W_IDLE: begin
                awready = aresetn;
                if (awvalid) w_state_nxt = W_DATA;
            end
            W_DATA: begin
                wready = 1'b1;
                if (wvalid && w_cnt == w_len) w_state_nxt = W_RESP;
            end
            W_RESP: begin
                bvalid = 1'b1;
                bresp  = w_err ? 2'b10 : 2'b00;
                if (bready) w_state_nxt = W_IDLE;
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else begin
            w_state <= w_state_nxt;
            if (w_state == W_IDLE && awvalid) begin
                w_id    <= awid;
                w_addr  <= awaddr;
                w_len   <= awlen;
                w_size  <= awsize;
                w_burst <= awburst;
                w_cnt   <= '0;
                w_err   <= 1'b0;
            end else if (w_state == W_DATA && wvalid) begin
                w_err <= w_err | w_oor;
                if (w_cnt != w_len) begin
                    w_addr <= next_addr(w_addr, w_size, w_burst);
                    w_cnt  <= w_cnt + 8'd1;
                end
            end
        end
    end

    // Array is deliberately not reset; reads in the same cycle see the old word
    always_ff @(posedge aclk) begin
        if (w_state == W_DATA && wvalid && !w_oor) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i]) mem[w_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, arlock, arcache, arprot, awlock, awcache, awprot, wid, wlast,
                         r_addr[31:ADDR_W+2], w_addr[31:ADDR_W+2]};
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb/tb_axi_sram_slave.sv - randomized self-checking bench for axi_sram_slave against an
// associative-array memory model; honours AXI_SLV_RANGE_CHECK_EN.
module tb_axi_sram_slave;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.ADDR_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit [31:0] mdl [int unsigned];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [31:0] beat_addr(bit [31:0] a, bit [2:0] size, bit [1:0] burst, int b);
        int unsigned step;
        step = (size > 3'd2) ? 4 : (1 << size);
        return (burst == 2'b00) ? a : a + b * step;
    endfunction

    function automatic bit is_oor(bit [31:0] a);
`ifdef AXI_SLV_RANGE_CHECK_EN
        return a[31:18] != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit [31:0] mdl_rd(bit [31:0] a);
        int unsigned idx;
        idx = a[17:2];
        return mdl.exists(idx) ? mdl[idx] : 32'd0;
    endfunction

    function automatic void mdl_wr(bit [31:0] a, bit [31:0] d, bit [3:0] s);
        int unsigned idx;
        bit [31:0] w;
        idx = a[17:2];
        w = mdl.exists(idx) ? mdl[idx] : 32'd0;
        for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
        mdl[idx] = w;
    endfunction

    task automatic axi_write(input bit [31:0] addr, input bit [7:0] len, input bit [2:0] size,
                             input bit [1:0] burst, input bit [3:0] id, input bit [31:0] dq[$],
                             input bit [3:0] sq[$], input int b_stall);
        int cnt;
        bit err;
        bit [31:0] a;
        err = 1'b0;
        @(negedge aclk);
        awvalid = 1; awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id;
        cnt = 0;
        while (!awready && cnt < 100) begin @(negedge aclk); cnt++; end
        check_eq("aw_handshake", awready, 1);
        @(negedge aclk);
        awvalid = 0;
        check_eq("wready_after_aw", wready, 1);
        for (int b = 0; b <= int'(len); b++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge aclk);
            wvalid = 1; wdata = dq[b]; wstrb = sq[b]; wlast = (b == int'(len));
            check_eq("bvalid_early", bvalid, 0);
            @(negedge aclk);
            wvalid = 0;
            a = beat_addr(addr, size, burst, b);
            if (is_oor(a)) err = 1'b1;
            else mdl_wr(a, dq[b], sq[b]);
        end
        check_eq("bvalid_latency", bvalid, 1);
        check_eq("bresp", bresp, {30'd0, err, 1'b0});
        check_eq("bid", bid, id);
        repeat (b_stall) begin
            @(negedge aclk);
            check_eq("bvalid_hold", {bvalid, bid, bresp}, {25'd0, 1'b1, id, err, 1'b0});
            check_eq("awready_during_b", awready, 0);
        end
        bready = 1;
        @(negedge aclk);
        bready = 0;
        check_eq("b_done", {bvalid, awready}, 2'b01);
    endtask

    task automatic axi_read(input bit [31:0] addr, input bit [7:0] len, input bit [2:0] size,
                            input bit [1:0] burst, input bit [3:0] id, input int r_stall);
        int cnt;
        int stall;
        bit [31:0] a, exp_d;
        bit [1:0] exp_r;
        @(negedge aclk);
        arvalid = 1; araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id;
        cnt = 0;
        while (!arready && cnt < 100) begin @(negedge aclk); cnt++; end
        check_eq("ar_handshake", arready, 1);
        @(negedge aclk);
        arvalid = 0;
        for (int b = 0; b <= int'(len); b++) begin
            a = beat_addr(addr, size, burst, b);
            exp_d = is_oor(a) ? 32'd0 : mdl_rd(a);
            exp_r = is_oor(a) ? 2'b10 : 2'b00;
            check_eq("rvalid", rvalid, 1);
            check_eq("rdata", rdata, exp_d);
            check_eq("rlast_rid_rresp", {rlast, rid, rresp}, {25'd0, b == int'(len), id, exp_r});
            stall = (b == 0) ? r_stall : int'($urandom_range(0, 1));
            repeat (stall) begin
                @(negedge aclk);
                check_eq("r_hold", {rvalid, rlast, rid, rresp}, {24'd0, 1'b1, b == int'(len), id, exp_r});
                check_eq("rdata_hold", rdata, exp_d);
            end
            rready = 1;
            @(negedge aclk);
            rready = 0;
        end
        check_eq("r_done", {rvalid, arready}, 2'b01);
    endtask

    bit [31:0] dq[$];
    bit [3:0]  sq[$];
    bit [31:0] old_w, base;
    bit [7:0]  rlen;
    bit [2:0]  rsz;
    bit [1:0]  rbt;

    initial begin
        aresetn = 0;
        {arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready} = '0;
        {awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid} = '0;
        {wid, wdata, wstrb, wlast, wvalid, bready} = '0;
        repeat (3) @(negedge aclk);
        check_eq("reset_outputs", {arready, awready, rvalid, rlast, wready, bvalid, rid, bid, rresp, bresp}, 0);
        check_eq("reset_rdata", rdata, 0);
        aresetn = 1;
        @(negedge aclk);
        check_eq("ready_after_release", {arready, awready}, 2'b11);

        dq = {}; sq = {};
        for (int i = 0; i < 256; i++) begin dq.push_back($urandom); sq.push_back(4'hF); end
        axi_write(32'h0, 8'd255, 3'd2, 2'b01, 4'h1, dq, sq, 0);

        dq = {32'hDEADBEEF}; sq = {4'hF};
        axi_write(32'h100, 8'd0, 3'd2, 2'b01, 4'h3, dq, sq, 0);
        axi_read(32'h100, 8'd0, 3'd2, 2'b01, 4'h5, 0);

        dq = {32'h11223344}; sq = {4'hF};
        axi_write(32'h200, 8'd0, 3'd2, 2'b01, 4'h2, dq, sq, 0);
        dq = {32'hAABBCCDD}; sq = {4'b0101};
        axi_write(32'h200, 8'd0, 3'd2, 2'b01, 4'h2, dq, sq, 0);
        axi_read(32'h200, 8'd0, 3'd2, 2'b01, 4'h6, 0);

        dq = {32'd1, 32'd2, 32'd3, 32'd4}; sq = {4'hF, 4'hF, 4'hF, 4'hF};
        axi_write(32'h300, 8'd3, 3'd2, 2'b01, 4'h7, dq, sq, 0);
        axi_read(32'h300, 8'd3, 3'd2, 2'b01, 4'h7, 0);
        dq = {32'd5, 32'd6, 32'd7, 32'd8};
        axi_write(32'h400, 8'd3, 3'd2, 2'b00, 4'h8, dq, sq, 0);
        axi_read(32'h400, 8'd0, 3'd2, 2'b01, 4'h8, 0);

        axi_read(32'h300, 8'd1, 3'd2, 2'b01, 4'hC, 3);
        dq = {32'hCAFEF00D}; sq = {4'hF};
        axi_write(32'h104, 8'd0, 3'd2, 2'b01, 4'hD, dq, sq, 5);

        // simultaneous AR and AW to the same word
        @(negedge aclk);
        arvalid = 1; araddr = 32'h18; arlen = 0; arsize = 2; arburst = 1; arid = 4'h9;
        awvalid = 1; awaddr = 32'h18; awlen = 0; awsize = 2; awburst = 1; awid = 4'hA;
        check_eq("conc_ready", {arready, awready}, 2'b11);
        @(negedge aclk);
        arvalid = 0; awvalid = 0;
        check_eq("conc_valid", {rvalid, wready}, 2'b11);
        old_w = mdl_rd(32'h18);
        rready = 1; wvalid = 1; wdata = $urandom; wstrb = 4'hF; wlast = 1;
        check_eq("same_word_old", rdata, old_w);
        @(negedge aclk);
        rready = 0; wvalid = 0;
        mdl_wr(32'h18, wdata, 4'hF);
        check_eq("conc_done", {rvalid, bvalid, bid}, {26'd0, 1'b0, 1'b1, 4'hA});
        bready = 1;
        @(negedge aclk);
        bready = 0;
        axi_read(32'h18, 8'd0, 3'd2, 2'b01, 4'h9, 0);

        // reset in the middle of a read burst
        @(negedge aclk);
        arvalid = 1; araddr = 32'h40; arlen = 7; arsize = 2; arburst = 1; arid = 4'hB;
        @(negedge aclk);
        arvalid = 0; rready = 1;
        repeat (2) @(negedge aclk);
        rready = 0;
        check_eq("mid_burst_rvalid", rvalid, 1);
        #2 aresetn = 0;
        #1;
        check_eq("async_reset_outputs", {arready, awready, rvalid, rlast, wready, bvalid, rid, bid, rresp, bresp}, 0);
        check_eq("async_reset_rdata", rdata, 0);
        @(negedge aclk);
        aresetn = 1;
        @(negedge aclk);
        check_eq("release_ready", {arready, awready, rvalid}, 3'b110);

        axi_read(32'h0004_0000, 8'd0, 3'd2, 2'b01, 4'h4, 0);
        dq = {32'h0BADBEEF}; sq = {4'hF};
        axi_write(32'h0004_0000, 8'd0, 3'd2, 2'b01, 4'h4, dq, sq, 0);
        axi_read(32'h0, 8'd0, 3'd2, 2'b01, 4'h4, 0);

        for (int it = 0; it < 40; it++) begin
            base = ($urandom_range(0, 127) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 3) == 0) base = base | ($urandom_range(1, 3) << 18);
            rlen = 8'($urandom_range(0, 15));
            rsz = 3'($urandom_range(0, 7));
            rbt = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) begin
                dq = {}; sq = {};
                for (int i = 0; i <= int'(rlen); i++) begin
                    dq.push_back($urandom); sq.push_back(4'($urandom));
                end
                axi_write(base, rlen, rsz, rbt, 4'($urandom), dq, sq, $urandom_range(0, 2));
            end else begin
                axi_read(base, rlen, rsz, rbt, 4'($urandom), $urandom_range(0, 2));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
